// File: rtl/id_ex_pipe_pkg.sv
// Shared types for the ID/EX pipeline register: the decoded control bundle,
// the per-cycle update selector and helpers that strip side-effecting enables.
package id_ex_pipe_pkg;

  localparam int BRANCH_W   = 3;
  localparam int WDSEL_W    = 2;
  localparam int ALUSRC_W   = 2;
  localparam int ALUFUNC_W  = 4;
  localparam int MEMSIZE_W  = 2;
  localparam int IMM_W      = 16;
  localparam int SHAMT_W    = 5;
  localparam int JAL_LINK_REG = 31;

  // Field order fixes the packed bit positions, isJmp in the MSB.
  typedef struct packed {
    logic                 isJmp;
    logic [BRANCH_W-1:0]  branch;
    logic [WDSEL_W-1:0]   rfWriteDataSel;
    logic                 rfWriteAddrSel;
    logic                 rfWriteEnable;
    logic                 memWrite;
    logic                 memRead;
    logic [ALUSRC_W-1:0]  aluSrc;
    logic                 aluSrc2;
    logic [ALUFUNC_W-1:0] aluFunc;
    logic                 bitXtend;
    logic [MEMSIZE_W-1:0] memDataSize;
    logic                 memBitExt;
    logic                 isJR;
    logic                 isJAL;
    logic                 invOpcode;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_FLUSH  = 2'd1,
    UPD_HOLD   = 2'd2,
    UPD_BUBBLE = 2'd3
  } upd_e;

  // A bubble must not write, touch memory or redirect the PC.
  function automatic ctrl_t killEnables(input ctrl_t c);
    ctrl_t r;
    r               = c;
    r.rfWriteEnable = 1'b0;
    r.memWrite      = 1'b0;
    r.memRead       = 1'b0;
    r.branch        = '0;
    r.isJmp         = 1'b0;
    r.isJR          = 1'b0;
    r.isJAL         = 1'b0;
    return r;
  endfunction

  // A trapping instruction keeps its identity but loses register/memory writes.
  function automatic ctrl_t clearWriteMem(input ctrl_t c);
    ctrl_t r;
    r               = c;
    r.rfWriteEnable = 1'b0;
    r.memWrite      = 1'b0;
    r.memRead       = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// Decode/EX handshake bundle for id_ex_pipe. master = surrounding core,
// slave = the pipeline register itself.
interface id_ex_pipe_if
  import id_ex_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) ();

   logic               id_valid;
   logic [XLEN-1:0]    id_pc;
   logic [REG_AW-1:0]  id_rs_addr;
   logic [REG_AW-1:0]  id_rt_addr;
   logic [REG_AW-1:0]  id_rd_addr;
   logic [XLEN-1:0]    id_rs_data;
   logic [XLEN-1:0]    id_rt_data;
   logic [IMM_W-1:0]   id_imm;
   logic [SHAMT_W-1:0] id_shamt;
   ctrl_t              id_ctrl;

   logic               ex_flush;
   logic               ex_hold;
   logic               id_stall;

   logic               ex_valid;
   logic [XLEN-1:0]    ex_pc;
   logic [XLEN-1:0]    ex_rs_data;
   logic [XLEN-1:0]    ex_rt_data;
   logic [IMM_W-1:0]   ex_imm;
   logic [SHAMT_W-1:0] ex_shamt;
   ctrl_t              ex_ctrl;
   logic [REG_AW-1:0]  ex_dest;
   logic               ex_trap;

   modport master (
      output id_valid, id_pc, id_rs_addr, id_rt_addr, id_rd_addr,
             id_rs_data, id_rt_data, id_imm, id_shamt, id_ctrl,
             ex_flush, ex_hold,
      input  id_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
             ex_shamt, ex_ctrl, ex_dest, ex_trap
   );

   modport slave (
      input  id_valid, id_pc, id_rs_addr, id_rt_addr, id_rd_addr,
             id_rs_data, id_rt_data, id_imm, id_shamt, id_ctrl,
             ex_flush, ex_hold,
      output id_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
             ex_shamt, ex_ctrl, ex_dest, ex_trap
   );

endinterface

// File: rtl/id_ex_pipe_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in decode. Purely combinational.
module load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic              exValid,
   input  logic              exMemRead,
   input  logic [REG_AW-1:0] exDest,
   input  logic [REG_AW-1:0] idRsAddr,
   input  logic [REG_AW-1:0] idRtAddr,
   input  logic              rtIsSrc,
   output logic              hazard
);

   logic rsHit;
   logic rtHit;

   assign rsHit  = (exDest == idRsAddr);
   assign rtHit  = rtIsSrc & (exDest == idRtAddr);
   // r0 is hard-wired zero, so a load into it never creates a dependency.
   assign hazard = exValid & exMemRead & (exDest != '0) & (rsHit | rtHit);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Define PIPE_PERF_CNT_EN to add the stall_cycles / flush_cycles counters.
module id_ex_pipe
   import id_ex_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   id_ex_pipe_if.slave     pipe
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] stall_cycles,
   output logic [XLEN-1:0] flush_cycles
`endif
);

   ctrl_t              idCtrl;
   logic [REG_AW-1:0]  idDest;
   logic               rtIsSrc;
   logic               rawHazard;
   logic               hazard;
   upd_e               upd;

   ctrl_t              loadCtrl;
   logic [REG_AW-1:0]  loadDest;
   logic               loadTrap;

   logic               exValidQ;
   logic               exTrapQ;
   logic [XLEN-1:0]    exPcQ;
   logic [XLEN-1:0]    exRsDataQ;
   logic [XLEN-1:0]    exRtDataQ;
   logic [IMM_W-1:0]   exImmQ;
   logic [SHAMT_W-1:0] exShamtQ;
   ctrl_t              exCtrlQ;
   logic [REG_AW-1:0]  exDestQ;

   assign idCtrl = pipe.id_ctrl;

   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so no path leaves it unassigned, which would infer a latch.
      idDest = pipe.id_rt_addr;
      if (idCtrl.isJAL) begin
         idDest = REG_AW'(JAL_LINK_REG);
      end else if (idCtrl.rfWriteAddrSel) begin
         idDest = pipe.id_rd_addr;
      end
      if (!idCtrl.rfWriteEnable) begin
         idDest = '0;
      end
   end

   // rt is only a pure destination for I-type writes (ADDI, LW, ...).
   assign rtIsSrc = !(idCtrl.rfWriteEnable & !idCtrl.rfWriteAddrSel & !idCtrl.isJAL);

   load_use_detect #(
      .REG_AW (REG_AW)
   ) u_loadUseDetect (
      .exValid   (exValidQ),
      .exMemRead (exCtrlQ.memRead),
      .exDest    (exDestQ),
      .idRsAddr  (pipe.id_rs_addr),
      .idRtAddr  (pipe.id_rt_addr),
      .rtIsSrc   (rtIsSrc),
      .hazard    (rawHazard)
   );

   assign hazard = rawHazard & pipe.id_valid;

   always_comb begin
      upd = UPD_LOAD;
      if (pipe.ex_flush) begin
         upd = UPD_FLUSH;
      end else if (pipe.ex_hold) begin
         upd = UPD_HOLD;
      end else if (hazard) begin
         upd = UPD_BUBBLE;
      end
   end

   // Gating with rst_n releases IF/ID the moment reset is asserted.
   assign pipe.id_stall = rst_n & ((upd == UPD_HOLD) | (upd == UPD_BUBBLE));

   always_comb begin
      loadCtrl = idCtrl;
      loadDest = idDest;
      loadTrap = 1'b0;
      if (!pipe.id_valid) begin
         loadCtrl = killEnables(idCtrl);
         loadDest = '0;
      end else if (idCtrl.invOpcode) begin
         loadCtrl = clearWriteMem(idCtrl);
         loadDest = '0;
         loadTrap = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         exValidQ  <= 1'b0;
         exTrapQ   <= 1'b0;
         exPcQ     <= '0;
         exRsDataQ <= '0;
         exRtDataQ <= '0;
         exImmQ    <= '0;
         exShamtQ  <= '0;
         exCtrlQ   <= '0;
         exDestQ   <= '0;
      end else begin
         unique case (upd)
            UPD_FLUSH, UPD_BUBBLE: begin
               exValidQ <= 1'b0;
               exTrapQ  <= 1'b0;
               exDestQ  <= '0;
               exCtrlQ  <= killEnables(exCtrlQ);
            end
            UPD_HOLD: begin
            end
            default: begin
               exValidQ  <= pipe.id_valid;
               exTrapQ   <= loadTrap;
               exPcQ     <= pipe.id_pc;
               exRsDataQ <= pipe.id_rs_data;
               exRtDataQ <= pipe.id_rt_data;
               exImmQ    <= pipe.id_imm;
               exShamtQ  <= pipe.id_shamt;
               exCtrlQ   <= loadCtrl;
               exDestQ   <= loadDest;
            end
         endcase
      end
   end

   assign pipe.ex_valid   = exValidQ;
   assign pipe.ex_trap    = exTrapQ;
   assign pipe.ex_pc      = exPcQ;
   assign pipe.ex_rs_data = exRsDataQ;
   assign pipe.ex_rt_data = exRtDataQ;
   assign pipe.ex_imm     = exImmQ;
   assign pipe.ex_shamt   = exShamtQ;
   assign pipe.ex_ctrl    = exCtrlQ;
   assign pipe.ex_dest    = exDestQ;

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (upd == UPD_BUBBLE) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (upd == UPD_FLUSH) begin
            flush_cycles <= flush_cycles + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe: reset, load-use bubble, false
// hazards, flush priority, hold, invalid opcode and reset during a stall.
module tb_id_ex_pipe;
   import id_ex_pipe_pkg::*;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   id_ex_pipe_if #(.XLEN(XLEN), .REG_AW(REG_AW)) pif ();

`ifdef PIPE_PERF_CNT_EN
   logic [XLEN-1:0] stallCycles;
   logic [XLEN-1:0] flushCycles;
`endif

   id_ex_pipe #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pipe  (pif.slave)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cycles (stallCycles),
      .flush_cycles (flushCycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic ctrl_t mkAdd();
      ctrl_t c = '0;
      c.rfWriteEnable  = 1'b1;
      c.rfWriteAddrSel = 1'b1;
      c.aluFunc        = 4'h2;
      return c;
   endfunction

   function automatic ctrl_t mkAddi();
      ctrl_t c = '0;
      c.rfWriteEnable = 1'b1;
      c.aluSrc        = 2'b01;
      c.aluFunc       = 4'h2;
      c.bitXtend      = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t mkLw();
      ctrl_t c = mkAddi();
      c.memRead        = 1'b1;
      c.rfWriteDataSel = 2'b01;
      c.memDataSize    = 2'b10;
      return c;
   endfunction

   function automatic ctrl_t mkSw();
      ctrl_t c = '0;
      c.memWrite    = 1'b1;
      c.aluSrc      = 2'b01;
      c.aluFunc     = 4'h2;
      c.memDataSize = 2'b10;
      return c;
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input ctrl_t c,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm);
      pif.id_valid   = v;
      pif.id_pc      = pc;
      pif.id_ctrl    = c;
      pif.id_rs_addr = rs;
      pif.id_rt_addr = rt;
      pif.id_rd_addr = rd;
      pif.id_rs_data = {16'h1000, 11'd0, rs};
      pif.id_rt_data = {16'h2000, 11'd0, rt};
      pif.id_imm     = imm;
      pif.id_shamt   = 5'd0;
   endtask

   initial begin
      ctrl_t invCtrl;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      pif.ex_flush = 1'b0;
      pif.ex_hold  = 1'b0;

      // Reset with random decode contents.
      pif.id_valid   = 1'b1;
      pif.id_pc      = $urandom;
      pif.id_ctrl    = ctrl_t'($urandom);
      pif.id_rs_addr = 5'($urandom);
      pif.id_rt_addr = 5'($urandom);
      pif.id_rd_addr = 5'($urandom);
      pif.id_rs_data = $urandom;
      pif.id_rt_data = $urandom;
      pif.id_imm     = 16'($urandom);
      pif.id_shamt   = 5'($urandom);
      tick();
      tick();
      check("rst_valid", 64'(pif.ex_valid), 64'd0);
      check("rst_trap",  64'(pif.ex_trap),  64'd0);
      check("rst_dest",  64'(pif.ex_dest),  64'd0);
      check("rst_pc",    64'(pif.ex_pc),    64'd0);
      check("rst_ctrl",  64'(pif.ex_ctrl),  64'd0);
      check("rst_stall", 64'(pif.id_stall), 64'd0);

      // First ADD r3,r1,r2 after release.
      drive(1'b1, 32'h100, mkAdd(), 5'd1, 5'd2, 5'd3, 16'h0000);
      pif.id_shamt = 5'd7;
      rst_n = 1'b1;
      tick();
      check("add_valid", 64'(pif.ex_valid),   64'd1);
      check("add_dest",  64'(pif.ex_dest),    64'd3);
      check("add_pc",    64'(pif.ex_pc),      64'h100);
      check("add_rs",    64'(pif.ex_rs_data), 64'h1000_0001);
      check("add_rt",    64'(pif.ex_rt_data), 64'h2000_0002);
      check("add_shamt", 64'(pif.ex_shamt),   64'd7);
      check("add_ctrl",  64'(pif.ex_ctrl),    64'(mkAdd()));

      // Load-use: LW r8,0(r4) then ADD r9,r8,r2.
      drive(1'b1, 32'h104, mkLw(), 5'd4, 5'd8, 5'd0, 16'h0000);
      tick();
      check("lw_dest", 64'(pif.ex_dest), 64'd8);
      drive(1'b1, 32'h108, mkAdd(), 5'd8, 5'd2, 5'd9, 16'h0000);
      #1;
      check("lu_stall", 64'(pif.id_stall), 64'd1);
      tick();
      check("lu_bubble_valid", 64'(pif.ex_valid),              64'd0);
      check("lu_bubble_memrd", 64'(pif.ex_ctrl.memRead),       64'd0);
      check("lu_bubble_we",    64'(pif.ex_ctrl.rfWriteEnable), 64'd0);
      check("lu_stall_drop",   64'(pif.id_stall),              64'd0);
      tick();
      check("lu_add_valid", 64'(pif.ex_valid), 64'd1);
      check("lu_add_dest",  64'(pif.ex_dest),  64'd9);
      check("lu_add_pc",    64'(pif.ex_pc),    64'h108);

      // No false hazard: rt is ADDI's destination.
      drive(1'b1, 32'h10c, mkLw(), 5'd4, 5'd8, 5'd0, 16'h0000);
      tick();
      drive(1'b1, 32'h110, mkAddi(), 5'd3, 5'd8, 5'd0, 16'h0004);
      #1;
      check("addi_nostall", 64'(pif.id_stall), 64'd0);
      tick();
      check("addi_dest", 64'(pif.ex_dest), 64'd8);
      check("addi_imm",  64'(pif.ex_imm),  64'h0004);

      // Load into r0 never stalls.
      drive(1'b1, 32'h114, mkLw(), 5'd4, 5'd0, 5'd0, 16'h0000);
      tick();
      check("lw0_dest", 64'(pif.ex_dest), 64'd0);
      drive(1'b1, 32'h118, mkAdd(), 5'd0, 5'd0, 5'd9, 16'h0000);
      #1;
      check("lw0_nostall", 64'(pif.id_stall), 64'd0);
      tick();

      // Flush beats hazard and hold.
      drive(1'b1, 32'h11c, mkLw(), 5'd4, 5'd8, 5'd0, 16'h0000);
      tick();
      drive(1'b1, 32'h120, mkAdd(), 5'd8, 5'd2, 5'd9, 16'h0000);
      pif.ex_flush = 1'b1;
      pif.ex_hold  = 1'b1;
      #1;
      check("fl_stall", 64'(pif.id_stall), 64'd0);
      tick();
      check("fl_valid", 64'(pif.ex_valid),              64'd0);
      check("fl_we",    64'(pif.ex_ctrl.rfWriteEnable), 64'd0);
      check("fl_memrd", 64'(pif.ex_ctrl.memRead),       64'd0);
      check("fl_memwr", 64'(pif.ex_ctrl.memWrite),      64'd0);
      pif.ex_hold = 1'b0;
      drive(1'b0, 32'h0, '0, 5'd0, 5'd0, 5'd0, 16'h0000);
      tick();
      check("fl2_valid", 64'(pif.ex_valid), 64'd0);
      pif.ex_flush = 1'b0;

      // Hold SW r5,8(r6) for three cycles.
      drive(1'b1, 32'h200, mkSw(), 5'd6, 5'd5, 5'd0, 16'h0008);
      tick();
      check("sw_dest", 64'(pif.ex_dest), 64'd0);
      drive(1'b1, 32'h204, mkAdd(), 5'd6, 5'd5, 5'd7, 16'h0000);
      pif.ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("hold_stall", 64'(pif.id_stall), 64'd1);
         tick();
         check("hold_pc",  64'(pif.ex_pc),            64'h200);
         check("hold_mw",  64'(pif.ex_ctrl.memWrite), 64'd1);
         check("hold_rt",  64'(pif.ex_rt_data),       64'h2000_0005);
      end
      pif.ex_hold = 1'b0;
      #1;
      check("hold_release_stall", 64'(pif.id_stall), 64'd0);
      check("hold_release_ctrl",  64'(pif.ex_ctrl),  64'(mkSw()));
      tick();
      check("post_hold_pc",   64'(pif.ex_pc),   64'h204);
      check("post_hold_dest", 64'(pif.ex_dest), 64'd7);
`ifdef PIPE_PERF_CNT_EN
      check("perf_stall", 64'(stallCycles), 64'd1);
      check("perf_flush", 64'(flushCycles), 64'd2);
`endif

      // Invalid opcode traps with writes stripped.
      invCtrl = mkAdd();
      invCtrl.memWrite  = 1'b1;
      invCtrl.invOpcode = 1'b1;
      drive(1'b1, 32'h300, invCtrl, 5'd1, 5'd2, 5'd4, 16'h0000);
      tick();
      check("inv_trap",  64'(pif.ex_trap),               64'd1);
      check("inv_valid", 64'(pif.ex_valid),              64'd1);
      check("inv_we",    64'(pif.ex_ctrl.rfWriteEnable), 64'd0);
      check("inv_mw",    64'(pif.ex_ctrl.memWrite),      64'd0);
      check("inv_dest",  64'(pif.ex_dest),               64'd0);

      // Invalid decode entry becomes a bubble.
      drive(1'b0, 32'h304, mkAdd(), 5'd1, 5'd2, 5'd4, 16'h0000);
      tick();
      check("idinv_valid", 64'(pif.ex_valid),              64'd0);
      check("idinv_trap",  64'(pif.ex_trap),               64'd0);
      check("idinv_we",    64'(pif.ex_ctrl.rfWriteEnable), 64'd0);

      // Reset asserted while a load-use stall is active.
      drive(1'b1, 32'h400, mkLw(), 5'd4, 5'd8, 5'd0, 16'h0000);
      tick();
      drive(1'b1, 32'h404, mkAdd(), 5'd8, 5'd2, 5'd9, 16'h0000);
      #1;
      check("mrst_pre_stall", 64'(pif.id_stall), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mrst_stall", 64'(pif.id_stall), 64'd0);
      check("mrst_valid", 64'(pif.ex_valid), 64'd0);
`ifdef PIPE_PERF_CNT_EN
      check("mrst_perf_stall", 64'(stallCycles), 64'd0);
`endif
      rst_n = 1'b1;
      tick();
      check("restart_valid", 64'(pif.ex_valid), 64'd1);
      check("restart_dest",  64'(pif.ex_dest),  64'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
